// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Optional architected branch delay slot with wait-state handling: BRANCH_DELAY_SLOT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
);

  logic [31:0] pc_q,         pc_d;
  logic [31:0] ifid_inst_q,  ifid_inst_d;
  logic [31:0] ifid_pc4_q,   ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] target;

`ifdef BRANCH_DELAY_SLOT_EN
  typedef enum logic {RUN, PEND} state_t;
  state_t      state_q,  state_d;
  logic [31:0] target_q, target_d;
`endif

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = (pcsource != 2'b00);

  always_comb begin
    target = pc_plus4;
    unique case (pcsource)
      2'b00: target = pc_plus4;
      2'b01: target = rpc;
      2'b10: target = bpc;
      2'b11: target = jpc;
    endcase
    target[1:0] = 2'b00;
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
`ifdef BRANCH_DELAY_SLOT_EN
    state_d      = state_q;
    target_d     = target_q;
`endif
    if (!stall) begin
      // Default to a bubble; the fetch branches below overwrite it.
      ifid_inst_d  = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      unique case (state_q)
        RUN: begin
          if (imem_ready) begin
            ifid_inst_d  = imem_inst;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            pc_d         = redirect ? target : pc_plus4;
          end else if (redirect) begin
            // Delay slot not yet fetched: park the target until it arrives.
            target_d = target;
            state_d  = PEND;
          end
        end
        PEND: begin
          if (imem_ready) begin
            ifid_inst_d  = imem_inst;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
            pc_d         = target_q;
            state_d      = RUN;
          end
        end
      endcase
`else
      if (redirect) begin
        pc_d = target;
      end else if (imem_ready) begin
        ifid_inst_d  = imem_inst;
        ifid_pc4_d   = pc_plus4;
        ifid_valid_d = 1'b1;
        pc_d         = pc_plus4;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pc_q         <= RESET_PC;
      ifid_inst_q  <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      state_q      <= RUN;
      target_q     <= '0;
`endif
    end else begin
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
`ifdef BRANCH_DELAY_SLOT_EN
      state_q      <= state_d;
      target_q     <= target_d;
`endif
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign ifid_inst  = ifid_inst_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_valid = ifid_valid_q;

endmodule
